md_sched: RTL and testbench

- Multiply/divide scheduler for the 5-stage MIPS pipeline (`mips` top, clk/reset only).
- Accepts mult/div/mthi/mtlo issued from the E stage and sequences a fixed-latency operation with a cycle counter.
- Owns the HI/LO architectural registers.
- Raises a stall request so the hazard logic freezes F/D while an MD instruction in D would conflict with an operation in flight.

---
 rtl/md_pkg.sv | 34 +++
 rtl/md_arith.sv | 59 +++++
 rtl/md_sched.sv | 119 +++++++++++
 tb/tb_md_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide scheduler.
package md_pkg;

  localparam int unsigned OP_W            = 3;
  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for multiple cycles.
  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the multiply ops (selects the shorter latency).
  function automatic logic is_mult_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing HI/LO results.
module md_arith
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next_c,
  output logic [WIDTH-1:0] lo_next_c,
  output logic             div_zero_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0] prod_s;
  logic [PW-1:0]        prod_u;
  logic                 b_zero;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     div_b;
  logic [WIDTH-1:0]     quo_u;
  logic [WIDTH-1:0]     rem_u;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // Signed division runs on magnitudes, then restores signs; this keeps
  // MIN/-1 well defined (magnitude 2^(W-1) wraps back to MIN).
  always_comb begin
    prod_s     = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    b_zero     = (b == '0);
    div_zero_c = b_zero && ((op == OP_DIV) || (op == OP_DIVU));
    sign_a     = (op == OP_DIV) && a[WIDTH-1];
    sign_b     = (op == OP_DIV) && b[WIDTH-1];
    mag_a      = sign_a ? (~a + WIDTH'(1)) : a;
    mag_b      = sign_b ? (~b + WIDTH'(1)) : b;
    div_b      = b_zero ? WIDTH'(1) : mag_b;
    quo_u      = mag_a / div_b;
    rem_u      = mag_a % div_b;
    quo_s      = (sign_a ^ sign_b) ? (~quo_u + WIDTH'(1)) : quo_u;
    rem_s      = sign_a ? (~rem_u + WIDTH'(1)) : rem_u;
    hi_next_c  = '0;
    lo_next_c  = '0;
    case (op)
      OP_MULT:         {hi_next_c, lo_next_c} = prod_s;
      OP_MULTU:        {hi_next_c, lo_next_c} = prod_u;
      OP_DIV, OP_DIVU: begin
        hi_next_c = rem_s;
        lo_next_c = quo_s;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: sequences fixed-latency ops, owns HI/LO, requests stalls.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             d_uses_md,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state;
  md_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [OP_W-1:0]  op_q;
  logic [OP_W-1:0]  op_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;
  logic             res_dz_c;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op         (op_q),
    .a          (a_q),
    .b          (b_q),
    .hi_next_c  (res_hi_c),
    .lo_next_c  (res_lo_c),
    .div_zero_c (res_dz_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state, operand capture, countdown and HI/LO update.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op_q;
    a_next     = a_q;
    b_next     = b_q;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_arith_op(op)) begin
            state_next = ST_BUSY;
            op_next    = op;
            a_next     = rs_val;
            b_next     = rt_val;
            cnt_next   = is_mult_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          end else if (op == OP_MTHI) begin
            hi_next = rs_val;
          end else if (op == OP_MTLO) begin
            lo_next = rs_val;
          end
        end
      end
      ST_BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = ST_IDLE;
          if (!res_dz_c) begin
            hi_next = res_hi_c;
            lo_next = res_lo_c;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers; busy mirrors the next state so it is a flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= OP_NOP;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      op_q <= op_next;
      a_q  <= a_next;
      b_q  <= b_next;
      hi   <= hi_next;
      lo   <= lo_next;
      busy <= (state_next == ST_BUSY);
    end
  end

  // Freeze F/D while an MD instruction in D would collide with an op in flight or launching.
  assign stall_req = d_uses_md & (busy | (start & is_arith_op(op)));

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO and latency queued at issue, checked at completion.
module tb_md_sched;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        d_uses_md = 1'b0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  md_sched #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Drive one start cycle on the falling edge and queue the expected result.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int cyc, input logic [31:0] eh, input logic [31:0] el,
                       input string nm);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    e.hi = eh; e.lo = el; e.cycles = cyc; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op = OP_NOP; rs_val = $urandom; rt_val = $urandom;
  endtask

  // Count remaining busy cycles, then pop and compare against the queue head.
  task automatic complete(input int already);
    int   n;
    exp_t e;
    n = already;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (n !== e.cycles) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", e.name, n, e.cycles);
    end
    n_checks++;
    if (hi !== e.hi) begin
      n_fail++;
      $display("FAIL %s_hi: got %h, required %h", e.name, hi, e.hi);
    end
    n_checks++;
    if (lo !== e.lo) begin
      n_fail++;
      $display("FAIL %s_lo: got %h, required %h", e.name, lo, e.lo);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++;
    if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h, required 0", hi); end
    n_checks++;
    if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h, required 0", lo); end
    n_checks++;
    if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", stall_req); end
  endtask

  task automatic test_directed();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
    complete(0);
    issue(OP_DIVU, 32'd100, 32'd7, DC, 32'd2, 32'd14, "divu");
    complete(0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    complete(0);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD, "div_negdivisor");
    complete(0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0, 32'h8000_0000, "div_overflow");
    complete(0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    complete(0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] pu;
    longint      sa, sbv, ps, q, r;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      pu = {32'h0, a} * {32'h0, b};
      issue(OP_MULTU, a, b, MC, pu[63:32], pu[31:0], "rand_multu");
      complete(0);
      sa = longint'($signed(a)); sbv = longint'($signed(b));
      ps = sa * sbv;
      issue(OP_MULT, a, b, MC, ps[63:32], ps[31:0], "rand_mult");
      complete(0);
      if (b == 32'h0) b = 32'd3;
      issue(OP_DIVU, a, b, DC, a % b, a / b, "rand_divu");
      complete(0);
      if (b == 32'hFFFF_FFFF) b = 32'd5;
      sbv = longint'($signed(b));
      q = sa / sbv; r = sa % sbv;
      issue(OP_DIV, a, b, DC, r[31:0], q[31:0], "rand_div");
      complete(0);
    end
  endtask

  task automatic test_stall();
    int n;
    d_uses_md = 1'b1;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs_val = 32'd50; rt_val = 32'd5;
    #1;
    n_checks++;
    if (stall_req !== 1'b1) begin n_fail++; $display("FAIL stall_start_cycle: got %b, required 1", stall_req); end
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n_checks++;
      if (stall_req !== 1'b1) begin n_fail++; $display("FAIL stall_busy_cycle%0d: got %b, required 1", n, stall_req); end
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== DC) begin n_fail++; $display("FAIL stall_div_cycles: got %0d, required %0d", n, DC); end
    n_checks++;
    if (stall_req !== 1'b0) begin n_fail++; $display("FAIL stall_first_idle: got %b, required 0", stall_req); end
    n_checks++;
    if (lo !== 32'd10 || hi !== 32'd0) begin
      n_fail++; $display("FAIL stall_div_result: got hi=%h lo=%h, required hi=0 lo=a", hi, lo);
    end
    start = 1'b1; op = OP_MTHI; rs_val = 32'h0000_0077;
    #1;
    n_checks++;
    if (stall_req !== 1'b0) begin n_fail++; $display("FAIL stall_mthi_start: got %b, required 0", stall_req); end
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    d_uses_md = 1'b0;
    issue(OP_MULT, 32'd3, 32'd4, MC, 32'd0, 32'd12, "stall_mult_nod");
    n_checks++;
    if (busy !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_no_d_use: got busy=%b stall=%b, required busy=1 stall=0", busy, stall_req);
    end
    complete(0);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; rs_val = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mthi: got hi=%h busy=%b, required hi=12345678 busy=0", hi, busy);
    end
    op = OP_MTLO; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n_checks++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b, required 12345678/9abcdef0/0", hi, lo, busy);
    end
    issue(OP_DIV, 32'hDEAD_0001, 32'h0, DC, 32'h1234_5678, 32'h9ABC_DEF0, "div_by_zero");
    complete(0);
  endtask

  task automatic test_start_while_busy();
    issue(OP_MULTU, 32'd6, 32'd7, MC, 32'd0, 32'd42, "start_while_busy");
    $display("note: injecting start during busy (protocol violation, must be ignored)");
    start = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    op = OP_DIV; rs_val = 32'd9; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    complete(2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; rs_val = 32'hA5A5_A5A5;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    issue(OP_DIV, 32'd1000, 32'd3, DC, 32'd1, 32'd333, "div_aborted");
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h, required all 0", busy, hi, lo);
    end
    #1 reset = 1'b0;
    sb.delete();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, MC, 32'd1, 32'hFFFF_FFFE, "multu_after_reset");
    complete(0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_mthi_mtlo();
    test_start_while_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
